// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared constants and types for the VGA pixel stream front end.
//            Holds the resolution constants, the RGB888 pixel struct, the
//            FIFO word layout (pixel plus start-of-frame flag) and the
//            stream alignment state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int H_ACT       = 640;
  localparam int V_ACT       = 480;
  localparam int FRAME_PIX   = H_ACT * V_ACT;
  localparam int PIX_CNT_W   = 19;
  localparam int FIFO_ADDR_W = 4;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic sof;
    rgb_t pix;
  } fifo_word_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vga_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vga_pix_fifo
// Purpose  : Single-clock synchronous FIFO with show-ahead output. The head
//            word is always visible on dout so the caller can inspect it
//            before deciding to pop.
// Ports    : clk, rst_n (sync, active low)
//            push/din  - write one word (ignored when full)
//            pop       - drop the head word (ignored when empty)
//            flush     - empty the FIFO; overrides push and pop
//            dout      - current head word
//            count     - occupancy, 0..2**ADDR_W
//            full/empty- occupancy flags decoded from count
// Revision : 1.0 - initial release
// ============================================================================
module vga_pix_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible because the
  // head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/vga_pix_stream.sv
`default_nettype none
// ============================================================================
// Module   : vga_pix_stream
// Purpose  : Buffers a valid/ready RGB888 stream and aligns it to the VGA
//            frame using the timing stage's frame_start and pix_req. One
//            registered pixel is produced per pix_req; underflow or stream
//            misalignment blacks out the output, raises a sticky flag and
//            re-synchronises on the next start-of-frame word.
// Ports    : clk, rst_n (sync, active low)
//            s_valid/s_ready/s_data/s_sof - upstream pixel stream
//            frame_start, pix_req         - from the timing stage
//            rgb_r/g/b, pix_valid         - registered pixel output
//            underflow, sync_err, clr_err - sticky error flags and clear
// Revision : 1.0 - initial release
// ============================================================================
module vga_pix_stream #(
  parameter int H_ACT     = vga_pkg::H_ACT,
  parameter int V_ACT     = vga_pkg::V_ACT,
  parameter int FRAME_PIX = H_ACT * V_ACT,
  parameter int ADDR_W    = vga_pkg::FIFO_ADDR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        frame_start,
  input  logic        pix_req,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        pix_valid,
  output logic        underflow,
  output logic        sync_err,
  input  logic        clr_err
);

  import vga_pkg::*;

  localparam logic [ADDR_W:0]      DEPTH_CNT = (ADDR_W + 1)'(1 << ADDR_W);
  localparam logic [PIX_CNT_W-1:0] LAST_PIX  = PIX_CNT_W'(FRAME_PIX - 1);

  state_t               state_q, state_d;
  logic [PIX_CNT_W-1:0] cnt_q, cnt_d;
  rgb_t                 pix_d;
  fifo_word_t           head;
  logic [ADDR_W:0]      fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 flush;
  logic                 set_uf;
  logic                 set_se;

  assign s_ready = (fifo_count != DEPTH_CNT);
  assign push    = s_valid & ~fifo_full;

  vga_pix_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W ($bits(fifo_word_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({s_sof, s_data}),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SYNC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    flush   = 1'b0;
    pix_d   = '0;
    set_uf  = 1'b0;
    set_se  = 1'b0;
    case (state_q)
      SYNC: begin
        // Drain words until a start-of-frame reaches the head.
        if (!fifo_empty) begin
          if (head.sof) state_d = ARMED;
          else          pop     = 1'b1;
        end
      end
      ARMED: begin
        if (frame_start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // A frame_start here means the frame never finished: resync, and
        // any coincident pix_req is left black.
        if (frame_start) begin
          set_se  = 1'b1;
          flush   = 1'b1;
          state_d = SYNC;
        end else if (pix_req) begin
          if (fifo_empty) begin
            set_uf  = 1'b1;
            flush   = 1'b1;
            state_d = SYNC;
          end else if (head.sof && (cnt_q != '0)) begin
            set_se  = 1'b1;
            flush   = 1'b1;
            state_d = SYNC;
          end else begin
            pop   = 1'b1;
            pix_d = head.pix;
            if (cnt_q == LAST_PIX) begin
              // Frame complete; next sof is found by the SYNC drain.
              cnt_d   = '0;
              state_d = SYNC;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_r     <= '0;
      rgb_g     <= '0;
      rgb_b     <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      rgb_r     <= pix_d.r;
      rgb_g     <= pix_d.g;
      rgb_b     <= pix_d.b;
      pix_valid <= pix_req;
      underflow <= set_uf | (underflow & ~clr_err);
      sync_err  <= set_se | (sync_err & ~clr_err);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_pix_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pix_stream
// Purpose  : Self-checking bench for vga_pix_stream on a reduced 8x4 frame.
//            A queue-based reference model follows the stream/frame rules;
//            every cycle the DUT outputs are compared against it, and a few
//            hand-derived literals pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pix_stream;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int FP   = H * V;
  localparam int HB   = 4;
  localparam int LEAD = 8;
  localparam int T    = LEAD + V * (H + HB);

  logic        clk = 1'b0;
  logic        rst_n, s_valid, s_ready, s_sof, frame_start, pix_req;
  logic        pix_valid, underflow, sync_err, clr_err;
  logic [23:0] s_data;
  logic [7:0]  rgb_r, rgb_g, rgb_b;

  always #5 clk = ~clk;

  vga_pix_stream #(.H_ACT(H), .V_ACT(V), .FRAME_PIX(FP), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .frame_start(frame_start),
    .pix_req(pix_req), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .pix_valid(pix_valid), .underflow(underflow), .sync_err(sync_err),
    .clr_err(clr_err)
  );

  int vecs = 0;
  int errs = 0;

  // ---------------- reference model ----------------
  logic [24:0] mq[$];
  int          m_st;      // 0 searching, 1 waiting for frame, 2 displaying
  int          m_cnt;
  int          m_shown = 0;
  logic [23:0] e_rgb = '0;
  logic        e_pv = 1'b0, e_uf = 1'b0, e_se = 1'b0, e_rdy = 1'b1;

  always @(posedge clk) begin : p_model
    logic [23:0] o;
    bit          pop, flush, suf, sse, push;
    if (!rst_n) begin
      mq.delete();
      m_st  = 0;
      m_cnt = 0;
      e_rgb = '0;
      e_pv  = 1'b0;
      e_uf  = 1'b0;
      e_se  = 1'b0;
    end else begin
      push = s_valid && (mq.size() < 16);
      o = '0; pop = 0; flush = 0; suf = 0; sse = 0;
      if (m_st == 0) begin
        if (mq.size() > 0) begin
          if (mq[0][24]) m_st = 1;
          else           pop = 1;
        end
      end else if (m_st == 1) begin
        if (frame_start) begin m_st = 2; m_cnt = 0; end
      end else begin
        if (frame_start) begin
          sse = 1; flush = 1; m_st = 0;
        end else if (pix_req) begin
          if (mq.size() == 0) begin
            suf = 1; flush = 1; m_st = 0;
          end else if (mq[0][24] && m_cnt != 0) begin
            sse = 1; flush = 1; m_st = 0;
          end else begin
            o = mq[0][23:0];
            pop = 1;
            m_shown++;
            m_cnt++;
            if (m_cnt == FP) begin m_cnt = 0; m_st = 0; end
          end
        end
      end
      if (flush) mq.delete();
      else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back({s_sof, s_data});
      end
      e_rgb = o;
      e_pv  = pix_req;
      e_uf  = suf || (e_uf && !clr_err);
      e_se  = sse || (e_se && !clr_err);
    end
    e_rdy = (mq.size() != 16);
  end

  // ---------------- stimulus state ----------------
  int          up_idx = 5;
  int          up_rate = 0, clr_rate = 0, rst_rate = 0, fs_glitch = 0;
  int          bad_sof = -1;
  int          tcnt = 0;
  bit          up_en = 0, tg_en = 0;
  logic [23:0] cur_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock from a negedge to the next negedge, checking outputs.
  task automatic tick();
    @(posedge clk);
    if (rst_n && s_valid && s_ready) begin
      up_idx   = (up_idx + 1) % FP;
      cur_data = 24'($urandom);
    end
    #1;
    chk("rgb", {8'h0, rgb_r, rgb_g, rgb_b}, {8'h0, e_rgb});
    chk("pix_valid", 32'(pix_valid), 32'(e_pv));
    chk("underflow", 32'(underflow), 32'(e_uf));
    chk("sync_err",  32'(sync_err),  32'(e_se));
    chk("s_ready",   32'(s_ready),   32'(e_rdy));
    @(negedge clk);
  endtask

  task automatic drive_auto();
    int p;
    s_valid     = up_en && ($urandom_range(0, 99) < up_rate);
    s_data      = cur_data;
    s_sof       = (up_idx == 0) || (up_idx == bad_sof);
    frame_start = 1'b0;
    pix_req     = 1'b0;
    if (tg_en) begin
      frame_start = (tcnt == 2) || ($urandom_range(0, 999) < fs_glitch);
      if (tcnt >= LEAD) begin
        p = tcnt - LEAD;
        pix_req = (p % (H + HB)) < H;
      end
      tcnt = (tcnt + 1) % T;
    end
    clr_err = $urandom_range(0, 99) < clr_rate;
    rst_n   = !($urandom_range(0, 999) < rst_rate);
  endtask

  task automatic run(input int n);
    repeat (n) begin drive_auto(); tick(); end
  endtask

  task automatic idle_inputs();
    s_valid = 0; s_sof = 0; s_data = '0; frame_start = 0; pix_req = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    tcnt   = 0;
    up_idx = 5;
  endtask

  int s0;

  initial begin
    cur_data = 24'($urandom);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset with 5 buffered words (sof head keeps them parked).
    s_valid = 1; s_sof = 1; s_data = 24'hA0A0A0; tick();
    s_sof = 0;
    for (int i = 0; i < 4; i++) begin s_data = 24'(i + 1); tick(); end
    s_valid = 0; tick();
    rst_n = 0; tick();
    chk("rst_rgb", {8'h0, rgb_r, rgb_g, rgb_b}, 32'h0);
    chk("rst_pv", 32'(pix_valid), 32'h0);
    chk("rst_flags", {30'h0, underflow, sync_err}, 32'h0);
    chk("rst_ready", 32'(s_ready), 32'h1);
    rst_n = 1;

    // Three stray words, then a sof frame start.
    s_valid = 1;
    for (int i = 0; i < 3; i++) begin s_data = 24'h0A0B00 + 24'(i); tick(); end
    s_sof = 1; s_data = 24'h112233; tick();
    s_sof = 0; s_data = 24'h445566; tick();
    s_valid = 0; repeat (4) tick();
    frame_start = 1; tick();
    frame_start = 0; pix_req = 1; tick();
    chk("px0", {8'h0, rgb_r, rgb_g, rgb_b}, 32'h00112233);
    chk("px0_valid", 32'(pix_valid), 32'h1);
    tick();
    chk("px1", {8'h0, rgb_r, rgb_g, rgb_b}, 32'h00445566);
    pix_req = 0; tick();
    chk("px_idle", {8'h0, rgb_r, rgb_g, rgb_b, 7'h0, pix_valid}, 32'h0);

    // FIFO fill limit and push/pop at the edge of full.
    do_reset();
    s_valid = 1; s_sof = 1; s_data = 24'h010101; tick();
    s_sof = 0;
    repeat (19) begin s_data = 24'($urandom); tick(); end
    chk("full_ready", 32'(s_ready), 32'h0);
    frame_start = 1; tick();
    frame_start = 0; pix_req = 1; tick();
    chk("pop_from_full", 32'(s_ready), 32'h1);
    tick();
    chk("push_pop_15", 32'(s_ready), 32'h1);
    pix_req = 0; tick();
    chk("refill_full", 32'(s_ready), 32'h0);

    // Clean full-rate stream: three complete frames in four periods.
    do_reset();
    up_en = 1; up_rate = 100; tg_en = 1; bad_sof = -1;
    s0 = m_shown;
    run(4 * T);
    chk("clean_frames", 32'(m_shown - s0), 32'(3 * FP));
    chk("clean_flags", {30'h0, underflow, sync_err}, 32'h0);

    // Upstream stalls: 16 buffered pixels, then underflow.
    do_reset();
    run(2 * T);
    up_en = 0;
    s0 = m_shown;
    run(T);
    chk("stall_pixels", 32'(m_shown - s0), 32'd16);
    chk("stall_uf", 32'(underflow), 32'h1);
    tg_en = 0; clr_rate = 100; run(1); clr_rate = 0;
    chk("clr_uf", 32'(underflow), 32'h0);

    // Stray sof mid-frame, then recovery.
    do_reset();
    up_en = 1; up_rate = 100; tg_en = 1; bad_sof = 10;
    run(3 * T);
    chk("bad_sof_se", 32'(sync_err), 32'h1);
    bad_sof = -1;
    run(2 * T);
    tg_en = 0; clr_rate = 100; run(1); clr_rate = 0; tg_en = 1;
    chk("clr_se", 32'(sync_err), 32'h0);
    s0 = m_shown;
    run(3 * T);
    chk("recover_flags", {30'h0, underflow, sync_err}, 32'h0);
    chk("recover_shown", 32'(m_shown - s0 >= 2 * FP), 32'h1);

    // Randomised traffic.
    for (int k = 0; k < 20; k++) begin
      up_rate   = $urandom_range(40, 100);
      fs_glitch = $urandom_range(0, 8);
      clr_rate  = $urandom_range(0, 5);
      rst_rate  = $urandom_range(0, 3);
      bad_sof   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FP - 1) : -1;
      run(T);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
